// File: rtl/cpu_trace_mon_pkg.sv
// Shared types for the CPU trace monitor: supervisor FSM states and the trace-entry record.
// Trace-entry fields are sized for the widest supported CPU (PC up to 32 bits, instruction up to 64).
package cpu_trace_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mon_state_t;

   localparam int TE_PC_W    = 32;
   localparam int TE_INSTR_W = 64;

   typedef struct packed {
      logic [TE_PC_W-1:0]    pc;
      logic [TE_INSTR_W-1:0] instr;
   } trace_entry_t;

endpackage

// File: rtl/cpu_trace_mon_if.sv
// Bus bundle between a CPU-side driver (master) and the trace monitor (slave).
interface cpu_trace_mon_if #(
   parameter int PC_WIDTH   = 8,
   parameter int DATA_W     = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int IDX_W = $clog2(DEPTH);

   logic                  en;
   logic [PC_WIDTH-1:0]   pc;
   logic [DATA_W-1:0]     instr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [IDX_W-1:0]      rd_idx;
   logic [PC_WIDTH-1:0]   rd_pc;
   logic [DATA_W-1:0]     rd_instr;
   logic [IDX_W:0]        trace_count;
   logic [31:0]           cycle_count;
   logic [DATA_W-1:0]     result;
   logic                  done;
   logic                  pass;
   logic                  fail;

   modport master (
      output en, pc, instr, wr_en, wr_addr, wr_data, rd_idx,
      input  rd_pc, rd_instr, trace_count, cycle_count, result, done, pass, fail
   );

   modport slave (
      input  en, pc, instr, wr_en, wr_addr, wr_data, rd_idx,
      output rd_pc, rd_instr, trace_count, cycle_count, result, done, pass, fail
   );

endinterface

// File: rtl/cpu_trace_mon_trace_ring.sv
// Circular trace buffer of {pc, instr}: one write port, saturating fill count,
// and a combinational read indexed from the oldest valid entry.
module trace_ring
   import cpu_trace_mon_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [PC_W-1:0]   o_rd_pc,
   output logic [DATA_W-1:0] o_rd_instr,
   output logic [IDX_W:0]    o_count
);

   localparam logic [IDX_W:0]   FULL = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   trace_entry_t         r_mem [DEPTH];
   logic [IDX_W-1:0]     r_wr_ptr;
   logic [IDX_W:0]       r_count;
   trace_entry_t         w_entry;
   logic [IDX_W-1:0]     w_slot;

   always_comb begin
      w_entry       = '0;
      w_entry.pc    = TE_PC_W'(i_pc);
      w_entry.instr = TE_INSTR_W'(i_instr);
   end

   // Storage is data only; no reset needed.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_wr_en) begin
         r_wr_ptr <= r_wr_ptr + ONE;
         if (r_count != FULL) begin
            r_count <= r_count + (IDX_W+1)'(1);
         end
      end
   end

   // When full, the low count bits are zero, so the oldest entry sits at the write pointer.
   assign w_slot     = r_wr_ptr - r_count[IDX_W-1:0] + i_rd_idx;
   assign o_rd_pc    = r_mem[w_slot].pc[PC_W-1:0];
   assign o_rd_instr = r_mem[w_slot].instr[DATA_W-1:0];
   assign o_count    = r_count;

endmodule

// File: rtl/cpu_trace_mon.sv
// CPU trace monitor: records fetched {pc, instr}, watches stores to RESULT_ADDR, and declares
// the program finished once the PC stays put for HALT_CYCLES enabled samples.
module cpu_trace_mon
   import cpu_trace_mon_pkg::*;
#(
   parameter int PC_WIDTH    = 8,
   parameter int DATA_W      = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4,
   parameter int RESULT_ADDR = 8,
   parameter int PASS_VALUE  = 1
) (
   input  logic           clk,
   input  logic           rst,
   cpu_trace_mon_if.slave bus
);

   localparam int HC_W = $clog2(HALT_CYCLES + 1);
   localparam logic [HC_W-1:0]       HALT_LIM  = HC_W'(HALT_CYCLES);
   localparam logic [HC_W-1:0]       HC_ONE    = HC_W'(1);
   localparam logic [ADDR_WIDTH-1:0] RES_ADDR  = ADDR_WIDTH'(RESULT_ADDR);
   localparam logic [DATA_W-1:0]     PASS_WORD = DATA_W'(PASS_VALUE);

   mon_state_t          r_state;
   mon_state_t          w_next_state;
   logic [HC_W-1:0]     r_halt_cnt;
   logic [HC_W-1:0]     w_halt_nxt;
   logic                w_halt_hit;
   logic                w_sample;
   logic                w_res_wr;
   logic [DATA_W-1:0]   w_result_nxt;
   logic [PC_WIDTH-1:0] r_prev_pc;
   logic [31:0]         r_cycle_cnt;
   logic [DATA_W-1:0]   r_result;
   logic                r_done;
   logic                r_pass;
   logic                r_fail;

   // The IDLE->RUN sample is recorded and counted like any other RUN sample.
   always_comb begin
      w_sample     = bus.en && (r_state != ST_DONE);
      w_res_wr     = bus.wr_en && (bus.wr_addr == RES_ADDR) && (r_state != ST_DONE);
      w_result_nxt = w_res_wr ? bus.wr_data : r_result;
      w_halt_nxt   = HC_ONE;
      if (bus.pc == r_prev_pc) begin
         w_halt_nxt = (r_halt_cnt == HALT_LIM) ? r_halt_cnt : r_halt_cnt + HC_ONE;
      end
      w_halt_hit   = w_sample && (r_state == ST_RUN) && (w_halt_nxt == HALT_LIM);
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (bus.en) w_next_state = ST_RUN;
         ST_RUN:  if (w_halt_hit) w_next_state = ST_DONE;
         ST_DONE: w_next_state = ST_DONE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_halt_cnt  <= '0;
         r_prev_pc   <= '0;
         r_cycle_cnt <= '0;
         r_result    <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_result <= w_result_nxt;
         if (w_sample) begin
            r_halt_cnt  <= w_halt_nxt;
            r_prev_pc   <= bus.pc;
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         end
         // Verdict uses the result as updated this cycle, so a store coinciding with halt counts.
         if (w_halt_hit) begin
            r_done <= 1'b1;
            r_pass <= (w_result_nxt == PASS_WORD);
            r_fail <= (w_result_nxt != PASS_WORD);
         end
      end
   end

   trace_ring #(
      .PC_W   (PC_WIDTH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ring (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_sample),
      .i_pc       (bus.pc),
      .i_instr    (bus.instr),
      .i_rd_idx   (bus.rd_idx),
      .o_rd_pc    (bus.rd_pc),
      .o_rd_instr (bus.rd_instr),
      .o_count    (bus.trace_count)
   );

   assign bus.cycle_count = r_cycle_cnt;
   assign bus.result      = r_result;
   assign bus.done        = r_done;
   assign bus.pass        = r_pass;
   assign bus.fail        = r_fail;

endmodule

// File: tb/tb_cpu_trace_mon.sv
// Directed bench for cpu_trace_mon: table-driven run/halt vectors plus hand sequences
// for trace fill/wrap, failing result, same-cycle store+halt and reset in DONE.
`timescale 1ns/1ps
module tb_cpu_trace_mon;
   import cpu_trace_mon_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   cpu_trace_mon_if #(.PC_WIDTH(8), .DATA_W(32), .ADDR_WIDTH(8), .DEPTH(16)) bus ();

   cpu_trace_mon #(
      .PC_WIDTH(8), .DATA_W(32), .ADDR_WIDTH(8), .DEPTH(16),
      .HALT_CYCLES(4), .RESULT_ADDR(8), .PASS_VALUE(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [7:0]  pc;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [4:0]  e_cnt;
      logic [31:0] e_cyc;
      logic [31:0] e_res;
      logic        e_done;
      logic        e_pass;
      logic        e_fail;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [7:0] p);
      return 32'hC0DE_0000 | {24'h0, p};
   endfunction

   task automatic step(input logic e, input logic [7:0] p, input logic we,
                       input logic [7:0] a, input logic [31:0] d);
      bus.en      = e;
      bus.pc      = p;
      bus.instr   = instr_of(p);
      bus.wr_en   = we;
      bus.wr_addr = a;
      bus.wr_data = d;
      @(posedge clk);
      #1;
      bus.en    = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   task automatic do_reset();
      bus.en = 1'b0; bus.wr_en = 1'b0; bus.pc = '0; bus.instr = '0;
      bus.wr_addr = '0; bus.wr_data = '0; bus.rd_idx = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] idx, input logic [7:0] exp_pc);
      bus.rd_idx = idx;
      #1;
      chk({name, "_pc"}, bus.rd_pc, exp_pc);
      chk({name, "_instr"}, bus.rd_instr, instr_of(exp_pc));
   endtask

   initial begin
      // en, pc, we, addr, data | count, cycles, result, done, pass, fail
      tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0, 5'd1, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 8'h04, 1'b1, 8'h08, 32'h1, 5'd2, 32'd2, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 8'h24, 1'b0, 8'h00, 32'h0, 5'd3, 32'd3, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 8'h24, 1'b0, 8'h00, 32'h0, 5'd4, 32'd4, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 8'h24, 1'b0, 8'h00, 32'h0, 5'd5, 32'd5, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'h28, 1'b0, 8'h00, 32'h0, 5'd6, 32'd6, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 8'h28, 1'b0, 8'h00, 32'h0, 5'd6, 32'd6, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 8'h28, 1'b0, 8'h00, 32'h0, 5'd6, 32'd6, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 8'h28, 1'b1, 8'h0C, 32'h7, 5'd6, 32'd6, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 8'h28, 1'b0, 8'h00, 32'h0, 5'd7, 32'd7, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 8'h28, 1'b0, 8'h00, 32'h0, 5'd8, 32'd8, 32'h1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 8'h28, 1'b0, 8'h00, 32'h0, 5'd9, 32'd9, 32'h1, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 8'h30, 1'b1, 8'h08, 32'h9, 5'd9, 32'd9, 32'h1, 1'b1, 1'b1, 1'b0};

      // Reset state, then ten sequential PCs
      do_reset();
      chk("rst_count", bus.trace_count, 5'd0);
      chk("rst_cycles", bus.cycle_count, 32'd0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_done", {bus.done, bus.pass, bus.fail}, 3'b000);
      for (int i = 0; i < 10; i++) step(1'b1, 8'(4 * i), 1'b0, 8'h00, 32'h0);
      chk("seq10_count", bus.trace_count, 5'd10);
      chk("seq10_cycles", bus.cycle_count, 32'd10);
      rd_chk("seq10_rd0", 4'd0, 8'h00);
      rd_chk("seq10_rd9", 4'd9, 8'h24);

      // Twenty PCs wrap a 16-deep ring
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 8'(4 * i), 1'b0, 8'h00, 32'h0);
      chk("wrap_count", bus.trace_count, 5'd16);
      chk("wrap_cycles", bus.cycle_count, 32'd20);
      rd_chk("wrap_rd0", 4'd0, 8'h10);
      rd_chk("wrap_rd15", 4'd15, 8'h4C);

      // Wrong result word, plus a store to a non-watched address
      do_reset();
      step(1'b1, 8'h00, 1'b1, 8'h08, 32'h5);
      step(1'b1, 8'h04, 1'b1, 8'h0C, 32'h9);
      chk("fail_res_other_addr", bus.result, 32'h5);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h24, 1'b0, 8'h00, 32'h0);
      chk("fail_not_yet_done", bus.done, 1'b0);
      step(1'b1, 8'h24, 1'b0, 8'h00, 32'h0);
      chk("fail_flags", {bus.done, bus.pass, bus.fail}, 3'b101);
      chk("fail_result", bus.result, 32'h5);

      // Store of the pass word in the very cycle the halt is detected
      do_reset();
      step(1'b1, 8'h10, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h24, 1'b0, 8'h00, 32'h0);
      chk("same_cyc_pre", {bus.done, bus.pass, bus.fail}, 3'b000);
      step(1'b1, 8'h24, 1'b1, 8'h08, 32'h1);
      chk("same_cyc_flags", {bus.done, bus.pass, bus.fail}, 3'b110);
      chk("same_cyc_result", bus.result, 32'h1);

      // Table: pass run with restart of the halt counter and an en-low freeze
      do_reset();
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].en, tbl[i].pc, tbl[i].we, tbl[i].addr, tbl[i].data);
         chk($sformatf("tbl%0d_count", i), bus.trace_count, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_cycles", i), bus.cycle_count, tbl[i].e_cyc);
         chk($sformatf("tbl%0d_result", i), bus.result, tbl[i].e_res);
         chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].e_done);
         chk($sformatf("tbl%0d_pass", i), bus.pass, tbl[i].e_pass);
         chk($sformatf("tbl%0d_fail", i), bus.fail, tbl[i].e_fail);
      end
      rd_chk("tbl_rd0", 4'd0, 8'h00);
      rd_chk("tbl_rd4", 4'd4, 8'h24);
      rd_chk("tbl_rd5", 4'd5, 8'h28);
      rd_chk("tbl_rd8", 4'd8, 8'h28);

      // Asynchronous reset while in DONE, checked before the next clock edge
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_flags", {bus.done, bus.pass, bus.fail}, 3'b000);
      chk("async_result", bus.result, 32'h0);
      chk("async_count", bus.trace_count, 5'd0);
      chk("async_cycles", bus.cycle_count, 32'd0);
      chk("async_state", dut.r_state, ST_IDLE);
      #2;
      rst = 1'b0;
      step(1'b1, 8'h40, 1'b0, 8'h00, 32'h0);
      chk("resume_state", dut.r_state, ST_RUN);
      chk("resume_count", bus.trace_count, 5'd1);
      chk("resume_cycles", bus.cycle_count, 32'd1);
      rd_chk("resume_rd0", 4'd0, 8'h40);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_trace_mon.md
CPU_TRACE_MON -- requirements
Module: cpu_trace_mon

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, width of the monitored PC.
REQ-002 SHALL have parameter DATA_W, default 32, width of the instruction, store-data and result words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, width of the data-memory write address.
REQ-004 SHALL have parameter DEPTH, default 16, trace entries (power of 2, >=2).
REQ-005 SHALL have parameter HALT_CYCLES, default 4, consecutive equal-PC cycles that declare halt (>=2).
REQ-006 SHALL have parameter RESULT_ADDR, default 8, the watched store address.
REQ-007 SHALL have parameter PASS_VALUE, default 1, the expected result word.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port en, input, 1, sample strobe; the CPU advanced this cycle.
REQ-011 SHALL have port pc, input, PC_WIDTH, the CPU fetch PC.
REQ-012 SHALL have port instr, input, DATA_W, the fetched instruction.
REQ-013 SHALL have port wr_en, input, 1, data-memory store strobe.
REQ-014 SHALL have port wr_addr, input, ADDR_WIDTH, the store address.
REQ-015 SHALL have port wr_data, input, DATA_W, the store data.
REQ-016 SHALL have port rd_idx, input, log2(DEPTH), trace read index; 0 is the oldest valid entry.
REQ-017 SHALL have port rd_pc, output, PC_WIDTH, the traced PC at rd_idx.
REQ-018 SHALL have port rd_instr, output, DATA_W, the traced instruction at rd_idx.
REQ-019 SHALL have port trace_count, output, log2(DEPTH)+1, the number of valid entries.
REQ-020 SHALL have port cycle_count, output, 32, the number of enabled cycles in RUN.
REQ-021 SHALL have port result, output, DATA_W, the last word stored to RESULT_ADDR.
REQ-022 SHALL have port done, output, 1, the halt has been detected.
REQ-023 SHALL have port pass, output, 1, done and result equals PASS_VALUE.
REQ-024 SHALL have port fail, output, 1, done and result differs from PASS_VALUE.

Function
REQ-025 SHALL implement the states IDLE, RUN and DONE: IDLE goes to RUN on the first en; RUN goes to DONE when the halt counter reaches HALT_CYCLES; DONE is held until rst.
REQ-026 In RUN with en high, SHALL write {pc, instr} into the ring at the write pointer and advance the pointer modulo DEPTH; the IDLE-to-RUN cycle also records its sample.
REQ-027 trace_count SHALL increment per recorded entry and saturate at DEPTH; once full, the oldest entry is overwritten.
REQ-028 Reads SHALL be combinational from physical slot (wr_ptr - trace_count + rd_idx) mod DEPTH; for rd_idx >= trace_count the read data is don't-care.
REQ-029 SHALL keep a halt counter: with en high, pc equal to the registered previous pc increments it (saturating); an unequal pc resets it to 1.
REQ-030 SHALL enter DONE in the cycle after the counter reaches HALT_CYCLES; done, pass and fail are registered and stable thereafter.
REQ-031 SHALL capture wr_data into result whenever wr_en is high and wr_addr equals RESULT_ADDR, in any state except DONE; a store and a halt in the same cycle SHALL use the new result for the pass/fail decision.
REQ-032 cycle_count SHALL increment on each en in RUN, wrapping at 2^32.
REQ-033 With en low, SHALL leave the trace, the halt counter and cycle_count unchanged.
REQ-034 pass and fail SHALL be mutually exclusive and both 0 while done is 0.

Reset
REQ-035 On rst, SHALL asynchronously set state=IDLE, wr_ptr=0, trace_count=0, cycle_count=0, halt counter=0, previous pc=0, result=0, done=0, pass=0 and fail=0; trace storage need not be cleared.
REQ-036 An rst asserted mid-RUN or in DONE SHALL discard all progress; normal operation resumes on the first en after release.

Structure
REQ-037 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the trace-entry struct {pc, instr}.
REQ-038 The ring buffer SHALL be a single sub-module, trace_ring (write port, pointer/count, indexed read).

Verification
REQ-039 Bench SHALL cover: rst then en with pc 0x00,0x04..0x24 -> trace_count=10, rd_idx=0 gives pc 0x00, rd_idx=9 gives 0x24.
REQ-040 Bench SHALL cover: 20 distinct PCs with DEPTH=16 -> trace_count=16, rd_idx=0 gives the 5th PC.
REQ-041 Bench SHALL cover: a store of 0x1 to address 8, then pc 0x24 held 4 enabled cycles -> done=1, pass=1, fail=0, result=0x1.
REQ-042 Bench SHALL cover: a store of 0x5 to address 8, then a halt -> fail=1, result=0x5; a store to address 12 leaves result unchanged.
REQ-043 Bench SHALL cover: pc 0x24 for 3 cycles, then 0x28 -> done stays 0 and the counter restarts; en low for several cycles mid-run leaves all counters frozen.
REQ-044 Bench SHALL cover: rst pulsed in DONE -> all outputs 0 and state IDLE within the same cycle.
